// File: rtl/dpll_loop_ctrl_if.sv
// Loop-control signal bundle between the DPLL phase detector / DCO side and dpll_loop_ctrl.
// The master drives enable and phase-detector samples; the slave returns DCO pulses and status.
interface dpll_loop_ctrl_if;
  logic       en;
  logic       pd_up;
  logic       pd_dn;
  logic       add;
  logic       sub;
  logic       locked;
  logic [1:0] state;

  modport master (output en, pd_up, pd_dn, input add, sub, locked, state);
  modport slave  (input en, pd_up, pd_dn, output add, sub, locked, state);
endinterface

// File: rtl/dpll_loop_ctrl.sv
// DPLL loop controller: dual K-counter filter producing DCO add/sub pulses, and
// correction-rate lock detection sequencing ACQUIRE (fast modulus) -> TRACK (slow modulus).
module dpll_loop_ctrl #(
  parameter int unsigned K_ACQ      = 4,
  parameter int unsigned K_TRK      = 16,
  parameter int unsigned WIN        = 64,
  parameter int unsigned LOCK_THR   = 1,
  parameter int unsigned LOCK_WINS  = 4,
  parameter int unsigned UNLOCK_THR = 3
) (
  input logic             clk,
  input logic             rst,
  dpll_loop_ctrl_if.slave bus
);

  localparam int unsigned KW = $clog2(K_TRK + 1);
  localparam int unsigned WW = $clog2(WIN + 1);
  localparam int unsigned QW = $clog2(LOCK_WINS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACQ  = 2'b01,
    S_TRK  = 2'b10
  } state_t;

  state_t        st;
  logic [KW-1:0] uc, dc;
  logic [WW-1:0] wcnt, ccnt;
  logic [QW-1:0] quiet;
  logic          add_q, sub_q, locked_q;

  logic [KW-1:0] k_last;
  logic          up_only, dn_only, carry_up, carry_dn, carry, win_end;
  logic [WW:0]   total;
  logic [QW-1:0] quiet_inc;

  always_comb begin
    k_last    = (st == S_TRK) ? KW'(K_TRK - 1) : KW'(K_ACQ - 1);
    up_only   = bus.pd_up & ~bus.pd_dn;
    dn_only   = bus.pd_dn & ~bus.pd_up;
    carry_up  = up_only && (uc == k_last);
    carry_dn  = dn_only && (dc == k_last);
    carry     = carry_up | carry_dn;
    win_end   = (wcnt == WW'(WIN - 1));
    total     = {1'b0, ccnt} + (WW + 1)'(carry);
    quiet_inc = quiet + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      st       <= S_IDLE;
      uc       <= '0;
      dc       <= '0;
      wcnt     <= '0;
      ccnt     <= '0;
      quiet    <= '0;
      add_q    <= 1'b0;
      sub_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          st    <= S_ACQ;
          add_q <= 1'b0;
          sub_q <= 1'b0;
        end
        S_ACQ, S_TRK: begin
          add_q <= carry_up;
          sub_q <= carry_dn;
          if (up_only) uc <= carry_up ? '0 : uc + 1'b1;
          if (dn_only) dc <= carry_dn ? '0 : dc + 1'b1;
          if (carry && ccnt != WW'(WIN)) ccnt <= ccnt + 1'b1;
          if (win_end) begin
            wcnt <= '0;
            ccnt <= '0;
            // Mode change: this edge's carry (old modulus) is already issued above;
            // the K-counters restart so the new modulus applies from the next sample.
            if (st == S_ACQ) begin
              if (total <= (WW + 1)'(LOCK_THR)) begin
                if (quiet_inc == QW'(LOCK_WINS)) begin
                  st       <= S_TRK;
                  locked_q <= 1'b1;
                  quiet    <= '0;
                  uc       <= '0;
                  dc       <= '0;
                end else begin
                  quiet <= quiet_inc;
                end
              end else begin
                quiet <= '0;
              end
            end else if (total > (WW + 1)'(UNLOCK_THR)) begin
              st       <= S_ACQ;
              locked_q <= 1'b0;
              quiet    <= '0;
              uc       <= '0;
              dc       <= '0;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          st    <= S_IDLE;
          add_q <= 1'b0;
          sub_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.add    = add_q;
  assign bus.sub    = sub_q;
  assign bus.locked = locked_q;
  assign bus.state  = st;

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// Directed bench for dpll_loop_ctrl with default parameters (K 4/16, window 64, 4 quiet windows).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_dpll_loop_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   nadd;

  always #5 clk = ~clk;

  dpll_loop_ctrl_if bus ();

  dpll_loop_ctrl #(
    .K_ACQ(4), .K_TRK(16), .WIN(64), .LOCK_THR(1), .LOCK_WINS(4), .UNLOCK_THR(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive into TRACK, preload uc to 15, then abort via en=0 or rst=1.
  task automatic abort_test(input bit use_rst);
    bus.pd_up = 1'b0; bus.pd_dn = 1'b0; bus.en = 1'b0;
    tick(); chk("t6_idle", {6'd0, bus.state}, 8'd0);
    bus.en = 1'b1;
    tick(); chk("t6_acq", {6'd0, bus.state}, 8'd1);
    repeat (256) tick();
    chk("t6_trk", {6'd0, bus.state}, 8'd2);
    chk("t6_lock", bus.locked, 1'b1);
    bus.pd_up = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(); chk("t6_pre_add", bus.add, 1'b0);
    end
    if (use_rst) rst = 1'b1; else bus.en = 1'b0;
    tick();
    chk("t6_abort_add", bus.add, 1'b0);
    chk("t6_abort_state", {6'd0, bus.state}, 8'd0);
    chk("t6_abort_lock", bus.locked, 1'b0);
    rst = 1'b0; bus.en = 1'b1;
    tick();
    chk("t6_restart_state", {6'd0, bus.state}, 8'd1);
    chk("t6_restart_add", bus.add, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick(); chk("t6_restart_k", bus.add, 8'(i == 4));
    end
  endtask

  initial begin
    // 1: reset held with en and pd_up active
    rst = 1'b1; bus.en = 1'b1; bus.pd_up = 1'b1; bus.pd_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_add", bus.add, 1'b0);
      chk("rst_sub", bus.sub, 1'b0);
      chk("rst_lock", bus.locked, 1'b0);
      chk("rst_state", {6'd0, bus.state}, 8'd0);
    end
    rst = 1'b0;
    tick(); chk("acq_entry", {6'd0, bus.state}, 8'd1);

    // 2: ACQUIRE, 16 up samples -> add on every 4th
    nadd = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t2_add", bus.add, 8'(i % 4 == 0));
      chk("t2_sub", bus.sub, 1'b0);
      if (bus.add) nadd++;
    end
    chk("t2_count", 8'(nadd), 8'd4);

    // 3: both asserted -> no counting
    bus.pd_dn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("t3_both_add", bus.add, 1'b0);
      chk("t3_both_sub", bus.sub, 1'b0);
    end
    chk("t3_state", {6'd0, bus.state}, 8'd1);
    bus.pd_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t3_dn_sub", bus.sub, 1'b0);
    end
    bus.pd_up = 1'b1; bus.pd_dn = 1'b0;
    tick();
    chk("t3_up_add", bus.add, 1'b0);
    chk("t3_up_sub", bus.sub, 1'b0);
    bus.pd_up = 1'b0; bus.pd_dn = 1'b1;
    tick();
    chk("t3_nocancel_sub", bus.sub, 1'b1);
    chk("t3_nocancel_add", bus.add, 1'b0);

    // 4: en low one cycle, then idle phase detector until lock
    bus.pd_up = 1'b0; bus.pd_dn = 1'b0; bus.en = 1'b0;
    tick();
    chk("t4_idle_state", {6'd0, bus.state}, 8'd0);
    chk("t4_idle_sub", bus.sub, 1'b0);
    bus.en = 1'b1;
    tick(); chk("t4_acq", {6'd0, bus.state}, 8'd1);
    for (int n = 1; n <= 256; n++) begin
      tick();
      if (n == 255) begin
        chk("t4_pre_state", {6'd0, bus.state}, 8'd1);
        chk("t4_pre_lock", bus.locked, 1'b0);
      end
      if (n == 256) begin
        chk("t4_lock_state", {6'd0, bus.state}, 8'd2);
        chk("t4_lock", bus.locked, 1'b1);
      end
    end

    // 5: TRACK with pd_up held -> 4 corrections in a window drops to ACQUIRE
    bus.pd_up = 1'b1;
    for (int n = 257; n <= 320; n++) begin
      tick();
      chk("t5_trk_add", bus.add, 8'((n - 256) % 16 == 0));
      if (n == 319) chk("t5_pre_state", {6'd0, bus.state}, 8'd2);
      if (n == 320) begin
        chk("t5_unlock_state", {6'd0, bus.state}, 8'd1);
        chk("t5_unlock_lock", bus.locked, 1'b0);
      end
    end
    for (int n = 321; n <= 328; n++) begin
      tick();
      chk("t5_acq_add", bus.add, 8'((n - 320) % 4 == 0));
    end

    // 6: abort mid-window with a pending carry, via en and via rst
    abort_test(1'b0);
    abort_test(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
